// File: rtl/lut_rsearch.sv
// Sequential linear search over a 32 x 8 lookup table (entry 0 reserved), one compare per cycle.
// Optional macro LUT_RSEARCH_EARLY_EXIT_EN: stop scanning on the first match.
module lut_rsearch (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [7:0] req_value,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [4:0] rsp_index,
    output logic       rsp_hit,
    input  logic       wr_en,
    input  logic [4:0] wr_index,
    input  logic [7:0] wr_data,
    output logic [1:0] state_dbg
);

    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid and its payload are held until that edge, and ready never depends on valid.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state, state_n;
    logic [4:0] ptr, ptr_n;
    logic [7:0] value_q, value_n;
    logic       hit_q, hit_n;
    logic [4:0] index_q, index_n;
    logic       last_q, last_n;
    logic [7:0] lut [32];
    logic       cmp_match;

    function automatic logic [7:0] reset_entry(input int unsigned i);
        case (i)
            1:       return 8'd0;
            2:       return 8'd1;
            3:       return 8'd9;
            4:       return 8'd10;
            5:       return 8'd26;
            6:       return 8'd54;
            7:       return 8'd61;
            8:       return 8'd64;
            9:       return 8'd65;
            10:      return 8'd75;
            default: return 8'd255;
        endcase
    endfunction

    // Reset restores the power-up contents, discarding any earlier writes.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 32; i++) lut[i] <= reset_entry(i);
        end else if (wr_en && (wr_index != 5'd0)) begin
            lut[wr_index] <= wr_data;
        end
    end

    // The table is registered, so a write landing on this edge is not seen by this compare.
    assign cmp_match = (lut[ptr] == value_q);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            ptr     <= 5'd1;
            value_q <= 8'd0;
            hit_q   <= 1'b0;
            index_q <= 5'd0;
            last_q  <= 1'b0;
        end else begin
            state   <= state_n;
            ptr     <= ptr_n;
            value_q <= value_n;
            hit_q   <= hit_n;
            index_q <= index_n;
            last_q  <= last_n;
        end
    end

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        value_n = value_q;
        hit_n   = hit_q;
        index_n = index_q;
        last_n  = last_q;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    value_n = req_value;
                    ptr_n   = 5'd1;
                    hit_n   = 1'b0;
                    index_n = 5'd0;
                    last_n  = 1'b0;
                    state_n = SCAN;
                end
            end
            SCAN: begin
                if (last_q) begin
                    // One settling cycle after the final compare before presenting the result.
                    state_n = DONE;
                end else begin
                    if (cmp_match && !hit_q) begin
                        hit_n   = 1'b1;
                        index_n = ptr;
                    end
`ifdef LUT_RSEARCH_EARLY_EXIT_EN
                    if (cmp_match) last_n = 1'b1;
`endif
                    if (ptr == 5'd31) last_n = 1'b1;
                    else ptr_n = ptr + 5'd1;
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_n = IDLE;
                    ptr_n   = 5'd1;
                    hit_n   = 1'b0;
                    index_n = 5'd0;
                    last_n  = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == DONE);
    assign rsp_index = index_q;
    assign rsp_hit   = hit_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_lut_rsearch.sv
// Directed bench for lut_rsearch: driver tasks push expected {hit, index, latency}; a negedge monitor pops and compares.
module tb_lut_rsearch;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_value;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [4:0] rsp_index;
    logic       rsp_hit;
    logic       wr_en;
    logic [4:0] wr_index;
    logic [7:0] wr_data;
    logic [1:0] state_dbg;

    localparam int W = 12;
    logic [W-1:0] exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cycle_cnt = 0;
    int t_acc = 0;
    bit seen = 0;

    lut_rsearch dut (
        .Clk(Clk), .Reset_n(Reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_value(req_value),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_index(rsp_index), .rsp_hit(rsp_hit),
        .wr_en(wr_en), .wr_index(wr_index), .wr_data(wr_data),
        .state_dbg(state_dbg)
    );

    // Clock / reset block
    always #5 Clk = ~Clk;
    always @(posedge Clk) cycle_cnt <= cycle_cnt + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [5:0] exp_lat(input logic hit, input logic [4:0] idx);
`ifdef LUT_RSEARCH_EARLY_EXIT_EN
        return hit ? ({1'b0, idx} + 6'd1) : 6'd32;
`else
        return 6'd32;
`endif
    endfunction

    // Driver tasks
    task automatic write_entry(input logic [4:0] idx, input logic [7:0] data);
        @(negedge Clk);
        wr_en = 1'b1; wr_index = idx; wr_data = data;
        @(posedge Clk);
        #1 wr_en = 1'b0;
    endtask

    task automatic start_req(input logic [7:0] value);
        int n;
        @(negedge Clk);
        req_valid = 1'b1; req_value = value;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge Clk);
            n++;
        end
        if (!req_ready) begin
            n_checks++; n_fail++;
            $display("FAIL req_accept: req_ready stayed 0 expected 1");
        end
        @(posedge Clk);
        #1;
        t_acc = cycle_cnt;
        req_valid = 1'b0;
        req_value = 8'($urandom_range(0, 255));
    endtask

    task automatic push_exp(input logic hit, input logic [4:0] idx);
        exp_q.push_back({hit, idx, exp_lat(hit, idx)});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge Clk);
            n++;
        end while (!(exp_q.size() == 0 && req_ready && !rsp_valid) && n < 200);
        if (n >= 200) begin
            n_checks++; n_fail++;
            $display("FAIL wait_idle: pending %0d expected 0", exp_q.size());
        end
    endtask

    task automatic search(input logic [7:0] value, input logic hit, input logic [4:0] idx);
        start_req(value);
        push_exp(hit, idx);
        wait_idle();
    endtask

    // Scoreboard monitor
    always @(negedge Clk) begin
        logic [W-1:0] e;
        if (!Reset_n) begin
            seen = 0;
        end else if (rsp_valid) begin
            if (!seen) begin
                seen = 1;
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected_rsp: got index %0d expected no response", rsp_index);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_hit", 32'(rsp_hit), 32'(e[11]));
                    chk("rsp_index", 32'(rsp_index), 32'(e[10:6]));
                    chk("rsp_latency", 32'(cycle_cnt - t_acc), 32'(e[5:0]));
                end
            end
            if (rsp_ready) seen = 0;
        end
    end

    initial begin
        int n;
        bit spurious;
        Reset_n = 1'b0; req_valid = 1'b0; req_value = 8'd0; rsp_ready = 1'b1;
        wr_en = 1'b0; wr_index = 5'd0; wr_data = 8'd0;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_rsp_index", 32'(rsp_index), 32'd0);
        chk("reset_rsp_hit", 32'(rsp_hit), 32'd0);

        search(8'd61, 1'b1, 5'd7);
        search(8'd200, 1'b0, 5'd0);

        // Result held while the consumer stalls; requests blocked.
        rsp_ready = 1'b0;
        start_req(8'd255);
        push_exp(1'b1, 5'd11);
        n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge Clk);
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_rsp_index", 32'(rsp_index), 32'd11);
            chk("hold_rsp_hit", 32'(rsp_hit), 32'd1);
            chk("hold_req_ready", 32'(req_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        wait_idle();

        write_entry(5'd0, 8'd123);
        search(8'd123, 1'b0, 5'd0);

        write_entry(5'd20, 8'd9);
        search(8'd9, 1'b1, 5'd3);
        write_entry(5'd3, 8'd77);
        search(8'd9, 1'b1, 5'd20);

        // Write lands on the same edge that closes the compare of entry 5.
        start_req(8'd99);
        push_exp(1'b0, 5'd0);
        repeat (4) @(posedge Clk);
        write_entry(5'd5, 8'd99);
        wait_idle();
        search(8'd99, 1'b1, 5'd5);

        // Abort mid-scan with reset: no response, table restored.
        start_req(8'd26);
        repeat (10) @(negedge Clk);
        #2 Reset_n = 1'b0;
        #2;
        chk("abort_rsp_valid_in_reset", 32'(rsp_valid), 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);
        chk("abort_req_ready", 32'(req_ready), 32'd1);
        spurious = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (rsp_valid) spurious = 1;
        end
        chk("abort_no_rsp", 32'(spurious), 32'd0);
        search(8'd26, 1'b1, 5'd5);
        search(8'd9, 1'b1, 5'd3);
        search(8'd99, 1'b0, 5'd0);

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lut_rsearch.md
LUT_RSEARCH -- requirements
Module: lut_rsearch

Interface
REQ-001 Clk  input  1  sole clock; all state updates on rising edge.
REQ-002 Reset_n  input  1  asynchronous, active-low reset.
REQ-003 req_valid  input  1  search request present.
REQ-004 req_ready  output  1  block can accept a request; high only in IDLE.
REQ-005 req_value  input  8  constant value to locate.
REQ-006 rsp_valid  output  1  search result present; high only in DONE.
REQ-007 rsp_ready  input  1  consumer accepts result.
REQ-008 rsp_index  output  5  index of first matching entry; 0 on miss.
REQ-009 rsp_hit  output  1  1 = match found, 0 = miss.
REQ-010 wr_en  input  1  table write strobe.
REQ-011 wr_index  input  5  entry to write; index 0 writes ignored.
REQ-012 wr_data  input  8  new entry value.

Function
REQ-013 Block SHALL hold a 32-entry x 8-bit table; entry 0 is reserved, never written, never matched.
REQ-014 FSM states SHALL be IDLE, SCAN, DONE.
REQ-015 IDLE: req_valid && req_ready at edge T SHALL latch req_value, set scan pointer to 1, enter SCAN.
REQ-016 SCAN: each cycle SHALL compare one entry (pointer k) against the latched value; the entry at index k is compared in the cycle after edge T+k-1, so pointer k spans T+k-1..T+k.
REQ-017 Lowest matching index SHALL be reported; later matches SHALL NOT overwrite it.
REQ-018 Scan SHALL end after index 31 compared (or earlier per REQ-030); next edge enters DONE.
REQ-019 DONE: rsp_valid=1, rsp_index/rsp_hit stable until rsp_valid && rsp_ready; that edge returns to IDLE.
REQ-020 Miss: rsp_hit=0, rsp_index=0.
REQ-021 Writes SHALL be accepted in any state; a write at edge E is visible to compares from the cycle after E onward.
REQ-022 Write and compare to the same index in the same cycle: compare SHALL use the pre-write value.
REQ-023 req_valid in SCAN/DONE SHALL be ignored (req_ready=0); requester holds req_value/req_valid until accepted.
REQ-024 req_value changes after acceptance SHALL NOT affect the in-flight search.
REQ-025 Pointer SHALL NOT wrap past 31; no index 0 compare.

Reset
REQ-026 Reset_n low SHALL asynchronously force: state IDLE, req_ready=1 after release, rsp_valid=0, rsp_index=0, rsp_hit=0, pointer=1.
REQ-027 Reset table contents: idx1=0, 2=1, 3=9, 4=10, 5=26, 6=54, 7=61, 8=64, 9=65, 10=75, all others (incl. 0) =255.
REQ-028 Reset asserted mid-SCAN or mid-DONE SHALL abort the search with no response and restore reset table contents (prior writes lost).
REQ-029 First request SHALL be accepted on the first edge with Reset_n high and req_valid high.

Configuration
REQ-030 Macro LUT_RSEARCH_EARLY_EXIT_EN defined: SCAN SHALL exit on first match; match at index k gives rsp_valid at cycle T+k+1 (miss still T+32).
REQ-031 Macro undefined: SCAN SHALL always compare all 31 entries; rsp_valid at T+32 regardless of hit; reported result identical to REQ-017.

Verification
REQ-032 Reset, request 61 -> rsp_hit=1, rsp_index=7; with EARLY_EXIT rsp_valid at T+8, without at T+32.
REQ-033 Reset, request 200 -> rsp_hit=0, rsp_index=0 at T+32 both configs.
REQ-034 Write idx20=9, request 9 -> rsp_index=3 (lowest match); write idx3=77, request 9 -> rsp_index=20.
REQ-035 Request 255 after reset -> rsp_index=11 (entry 0 excluded); hold rsp_ready=0 for 5 cycles -> outputs stable, req_ready=0.
REQ-036 Write idx5=26 -> 99 during SCAN at pointer 5 same cycle -> request 99 misses that compare, hits only if rescanned; Reset_n pulsed mid-SCAN -> no rsp_valid, table restored, request 26 -> rsp_index=5.
